// File: rtl/be_pkg.sv
// Shared back-end types: RV32I operand/op types and the ALU arbiter state encoding.
package be_pkg;

  typedef logic [31:0] RV32I_OPERAND_t;

  typedef enum logic [3:0] {
    ADD_alu  = 4'd0,
    SUB_alu  = 4'd1,
    SLL_alu  = 4'd2,
    SLT_alu  = 4'd3,
    SLTU_alu = 4'd4,
    XOR_alu  = 4'd5,
    SRL_alu  = 4'd6,
    SRA_alu  = 4'd7,
    OR_alu   = 4'd8,
    AND_alu  = 4'd9
  } RV32I_ALU_OP_t;

  // Arbiter sequencing: accept in IDLE, one ALU cycle in EXEC, hold result in RESP.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } ALU_ARB_STATE_t;

  localparam int ALU_ARB_MAX_REQ = 8;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: finds the first set request at or after i_ptr,
// wrapping modulo N. Purely combinational so any arbiter can reuse it.
module rr_priority_picker #(
  parameter int N    = 2,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [N-1:0]    o_gnt,
  output logic [ID_W-1:0] o_idx,
  output logic            o_any
);

  // Walk offsets from farthest to nearest so the closest requester after the pointer wins.
  always_comb begin
    int j;
    j     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(i_ptr) + k) % N;
      if (i_req[j]) begin
        o_gnt    = '0;
        o_gnt[j] = 1'b1;
        o_idx    = ID_W'(j);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rv32i_alu_arbiter.sv
// Shares one external RV32I ALU between N_REQ requesters.
// Handshake rule (both channels): a transfer happens on a rising clk edge where
// valid and ready are both high; a valid request keeps its fields stable until
// accepted, and resp_valid/resp_data hold stable until resp_ready of the
// granted requester is seen. One operation in flight: accept, execute, respond.
module rv32i_alu_arbiter
  import be_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic           [N_REQ-1:0]      req_valid,
  output logic           [N_REQ-1:0]      req_ready,
  input  RV32I_OPERAND_t [N_REQ-1:0]      req_a,
  input  RV32I_OPERAND_t [N_REQ-1:0]      req_b,
  input  RV32I_ALU_OP_t  [N_REQ-1:0]      req_op,
  output logic           [N_REQ-1:0]      resp_valid,
  input  logic           [N_REQ-1:0]      resp_ready,
  output RV32I_OPERAND_t                  resp_data,
  output RV32I_OPERAND_t                  alu_a,
  output RV32I_OPERAND_t                  alu_b,
  output RV32I_ALU_OP_t                   alu_op,
  input  RV32I_OPERAND_t                  alu_out,
  output logic                            busy,
  output ALU_ARB_STATE_t                  dbg_state
);

  ALU_ARB_STATE_t r_state;
  ALU_ARB_STATE_t w_state_nxt;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] r_gnt_id;
  RV32I_OPERAND_t  r_a;
  RV32I_OPERAND_t  r_b;
  RV32I_ALU_OP_t   r_op;
  RV32I_OPERAND_t  r_result;

  logic [N_REQ-1:0] w_gnt;
  logic [ID_W-1:0]  w_idx;
  logic             w_any;
  logic             w_accept;
  logic             w_resp_hs;
  logic [ID_W-1:0]  w_ptr_nxt;

  rr_priority_picker #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_picker (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_accept  = (r_state == IDLE) && w_any;
  assign w_resp_hs = (r_state == RESP) && resp_ready[r_gnt_id];
  assign w_ptr_nxt = (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic and per-state handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    resp_valid  = '0;
    unique case (r_state)
      IDLE: begin
        req_ready = w_gnt;
        if (w_accept) w_state_nxt = EXEC;
      end
      EXEC: w_state_nxt = RESP;
      RESP: begin
        resp_valid[r_gnt_id] = 1'b1;
        if (w_resp_hs) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept, result capture in EXEC, pointer advance past the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_gnt_id <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= ADD_alu;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_a      <= req_a[w_idx];
        r_b      <= req_b[w_idx];
        r_op     <= req_op[w_idx];
        r_gnt_id <= w_idx;
        r_rr_ptr <= w_ptr_nxt;
      end
      if (r_state == EXEC) r_result <= alu_out;
    end
  end

  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_op    = r_op;
  assign resp_data = r_result;
  assign busy      = (r_state != IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_rv32i_alu_arbiter.sv
// Directed bench for rv32i_alu_arbiter: a 2-requester instance for the main
// sequencing cases and a 4-requester instance for round-robin wrap.
module tb_rv32i_alu_arbiter;
  import be_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst  = 1'b1;
  logic rst4 = 1'b1;

  // ---------------- 2-requester DUT ----------------
  logic           [1:0] req_valid  = '0;
  logic           [1:0] req_ready;
  RV32I_OPERAND_t [1:0] req_a      = '0;
  RV32I_OPERAND_t [1:0] req_b      = '0;
  RV32I_ALU_OP_t  [1:0] req_op     = {ADD_alu, ADD_alu};
  logic           [1:0] resp_valid;
  logic           [1:0] resp_ready = '0;
  RV32I_OPERAND_t       resp_data;
  RV32I_OPERAND_t       alu_a, alu_b, alu_out;
  RV32I_ALU_OP_t        alu_op;
  logic                 busy;
  ALU_ARB_STATE_t       dbg_state;

  // ---------------- 4-requester DUT ----------------
  logic           [3:0] req_valid4  = '0;
  logic           [3:0] req_ready4;
  RV32I_OPERAND_t [3:0] req_a4      = '0;
  RV32I_OPERAND_t [3:0] req_b4      = '0;
  RV32I_ALU_OP_t  [3:0] req_op4     = {ADD_alu, ADD_alu, ADD_alu, ADD_alu};
  logic           [3:0] resp_valid4;
  logic           [3:0] resp_ready4 = '0;
  RV32I_OPERAND_t       resp_data4;
  RV32I_OPERAND_t       alu_a4, alu_b4, alu_out4;
  RV32I_ALU_OP_t        alu_op4;
  logic                 busy4;
  ALU_ARB_STATE_t       dbg_state4;

  // Reference RV32I ALU standing in for the external unit.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input RV32I_ALU_OP_t op);
    case (op)
      ADD_alu:  return a + b;
      SUB_alu:  return a - b;
      SLL_alu:  return a << b[4:0];
      SLT_alu:  return {31'd0, $signed(a) < $signed(b)};
      SLTU_alu: return {31'd0, a < b};
      XOR_alu:  return a ^ b;
      SRL_alu:  return a >> b[4:0];
      SRA_alu:  return $unsigned($signed(a) >>> b[4:0]);
      OR_alu:   return a | b;
      AND_alu:  return a & b;
      default:  return '0;
    endcase
  endfunction

  assign alu_out  = alu_f(alu_a, alu_b, alu_op);
  assign alu_out4 = alu_f(alu_a4, alu_b4, alu_op4);

  rv32i_alu_arbiter #(.N_REQ(2)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_out    (alu_out),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  rv32i_alu_arbiter #(.N_REQ(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst4),
    .req_valid  (req_valid4),
    .req_ready  (req_ready4),
    .req_a      (req_a4),
    .req_b      (req_b4),
    .req_op     (req_op4),
    .resp_valid (resp_valid4),
    .resp_ready (resp_ready4),
    .resp_data  (resp_data4),
    .alu_a      (alu_a4),
    .alu_b      (alu_b4),
    .alu_op     (alu_op4),
    .alu_out    (alu_out4),
    .busy       (busy4),
    .dbg_state  (dbg_state4)
  );

  // ---------------- scoreboard counters / driver tasks ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive point: just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample point: falling edge.
  task automatic smp();
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int p, g;

    // ===== reset =====
    tick();
    tick();
    smp();
    chk("rst_req_ready",  32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_data",  resp_data, 32'h0);
    chk("rst_alu_a",      alu_a, 32'h0);
    chk("rst_alu_b",      alu_b, 32'h0);
    chk("rst_alu_op",     32'(alu_op), 32'h0);
    chk("rst_busy",       32'(busy), 32'h0);
    chk("rst_state",      32'(dbg_state), 32'(IDLE));

    // ===== 1: single request on requester 0, 5 + 3 =====
    tick();
    rst = 1'b0; rst4 = 1'b0;
    req_valid = 2'b01; req_a[0] = 32'd5; req_b[0] = 32'd3; req_op[0] = ADD_alu;
    resp_ready = 2'b11;
    smp();
    chk("t1_req_ready_idle", 32'(req_ready), 32'h1);
    chk("t1_busy_idle",      32'(busy), 32'h0);
    tick();
    req_valid = 2'b00;
    smp();
    chk("t1_state_exec", 32'(dbg_state), 32'(EXEC));
    chk("t1_busy_exec",  32'(busy), 32'h1);
    chk("t1_req_ready_exec", 32'(req_ready), 32'h0);
    chk("t1_alu_a", alu_a, 32'd5);
    chk("t1_alu_b", alu_b, 32'd3);
    chk("t1_alu_op", 32'(alu_op), 32'(ADD_alu));
    chk("t1_resp_valid_exec", 32'(resp_valid), 32'h0);
    tick();
    smp();
    chk("t1_resp_valid", 32'(resp_valid), 32'h1);
    chk("t1_resp_data",  resp_data, 32'd8);
    chk("t1_busy_resp",  32'(busy), 32'h1);
    tick();
    smp();
    chk("t1_busy_done",       32'(busy), 32'h0);
    chk("t1_resp_valid_done", 32'(resp_valid), 32'h0);
    chk("t1_alu_a_hold",      alu_a, 32'd5);

    // ===== 2: both requesters valid continuously, pointer at 0 =====
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 2'b11;
    req_a[0] = 32'd10; req_b[0] = 32'd4;          req_op[0] = SUB_alu;
    req_a[1] = 32'd1;  req_b[1] = 32'hFFFF_FFFF;  req_op[1] = ADD_alu;
    resp_ready = 2'b11;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) tick();
      smp();
      p = c % 3;
      g = (c / 3) % 2;
      chk($sformatf("t2_req_ready_c%0d", c),  32'(req_ready),  (p == 0) ? (32'h1 << g) : 32'h0);
      chk($sformatf("t2_resp_valid_c%0d", c), 32'(resp_valid), (p == 2) ? (32'h1 << g) : 32'h0);
      chk($sformatf("t2_busy_c%0d", c),       32'(busy),       (p != 0) ? 32'h1 : 32'h0);
      if (p == 2)
        chk($sformatf("t2_resp_data_c%0d", c), resp_data, (g == 0) ? 32'd6 : 32'd0);
    end

    // ===== 3: backpressure on the response channel =====
    tick();
    rst = 1'b1;
    resp_ready = 2'b00;
    tick();
    rst = 1'b0;
    smp();
    chk("t3_req_ready_idle", 32'(req_ready), 32'h1);
    tick();
    smp();
    chk("t3_state_exec", 32'(dbg_state), 32'(EXEC));
    for (int s = 2; s <= 5; s++) begin
      tick();
      if (s == 5) resp_ready = 2'b01;
      smp();
      chk($sformatf("t3_resp_valid_s%0d", s), 32'(resp_valid), 32'h1);
      chk($sformatf("t3_resp_data_s%0d", s),  resp_data, 32'd6);
      chk($sformatf("t3_req_ready_s%0d", s),  32'(req_ready), 32'h0);
    end
    tick();
    smp();
    chk("t3_state_idle_again", 32'(dbg_state), 32'(IDLE));
    chk("t3_grant_to_1",       32'(req_ready), 32'h2);

    // ===== 4: ready on the wrong port is ignored =====
    tick();
    smp();
    chk("t4_state_exec", 32'(dbg_state), 32'(EXEC));
    tick();
    smp();
    chk("t4_resp_valid_1", 32'(resp_valid), 32'h2);
    chk("t4_resp_data",    resp_data, 32'd0);
    tick();
    resp_ready = 2'b10;
    smp();
    chk("t4_still_resp",     32'(dbg_state), 32'(RESP));
    chk("t4_resp_valid_hold", 32'(resp_valid), 32'h2);
    tick();
    smp();
    chk("t4_back_idle", 32'(dbg_state), 32'(IDLE));
    chk("t4_busy",      32'(busy), 32'h0);
    chk("t4_grant_0",   32'(req_ready), 32'h1);

    // ===== 5: reset during EXEC abandons the operation =====
    tick();
    rst = 1'b1;
    req_valid = 2'b00;
    smp();
    chk("t5_state_exec", 32'(dbg_state), 32'(EXEC));
    tick();
    rst = 1'b0;
    smp();
    chk("t5_state",      32'(dbg_state), 32'(IDLE));
    chk("t5_req_ready",  32'(req_ready), 32'h0);
    chk("t5_resp_valid", 32'(resp_valid), 32'h0);
    chk("t5_resp_data",  resp_data, 32'h0);
    chk("t5_alu_a",      alu_a, 32'h0);
    chk("t5_alu_b",      alu_b, 32'h0);
    chk("t5_alu_op",     32'(alu_op), 32'h0);
    chk("t5_busy",       32'(busy), 32'h0);
    tick();
    smp();
    chk("t5_no_stale_resp", 32'(resp_valid), 32'h0);
    req_valid = 2'b10; req_a[1] = 32'd7; req_b[1] = 32'd9; req_op[1] = ADD_alu;
    resp_ready = 2'b11;
    #1;
    chk("t5_fresh_req_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    smp();
    chk("t5_fresh_exec", 32'(dbg_state), 32'(EXEC));
    tick();
    smp();
    chk("t5_fresh_resp_valid", 32'(resp_valid), 32'h2);
    chk("t5_fresh_resp_data",  resp_data, 32'd16);
    tick();
    smp();
    chk("t5_fresh_done", 32'(busy), 32'h0);

    // ===== 6: N_REQ=4, req_valid=1010 starting from pointer 2 =====
    tick();
    req_valid4 = 4'b0010;
    resp_ready4 = 4'b1111;
    smp();
    chk("t6_prime_grant_1", 32'(req_ready4), 32'h2);
    tick();
    req_valid4 = 4'b1010;
    req_a4[3] = 32'd100;         req_b4[3] = 32'd1; req_op4[3] = SLL_alu;
    req_a4[1] = 32'h8000_0000;   req_b4[1] = 32'd4; req_op4[1] = SRA_alu;
    tick();
    tick();
    smp();
    chk("t6_grant_3_first", 32'(req_ready4), 32'h8);
    tick();
    tick();
    smp();
    chk("t6_resp_valid_3", 32'(resp_valid4), 32'h8);
    chk("t6_resp_data_3",  resp_data4, 32'd200);
    tick();
    smp();
    chk("t6_grant_1", 32'(req_ready4), 32'h2);
    tick();
    tick();
    smp();
    chk("t6_resp_valid_1", 32'(resp_valid4), 32'h2);
    chk("t6_resp_data_1",  resp_data4, 32'hF800_0000);
    tick();
    smp();
    chk("t6_grant_3_again", 32'(req_ready4), 32'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
